// File: rtl/result_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// result_tx_serializer_if
//
// Bundles the signals around the result transmit serializer:
//   - control-unit side : begin_transmission, data_in  -> serializer
//                         tx_sent, busy                <- serializer
//   - UART side         : tx_busy                      -> serializer
//                         tx_data, tx_start            <- serializer
//
// Modports:
//   slave  : the serializer itself
//   master : everything around it (control unit + UART transmitter)
// -----------------------------------------------------------------------------
interface result_tx_serializer_if #(
    parameter int WORD_WIDTH = 32
) ();

    logic                  begin_transmission;
    logic [WORD_WIDTH-1:0] data_in;
    logic                  tx_busy;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_sent;
    logic                  busy;

    modport slave (
        input  begin_transmission,
        input  data_in,
        input  tx_busy,
        output tx_data,
        output tx_start,
        output tx_sent,
        output busy
    );

    modport master (
        output begin_transmission,
        output data_in,
        output tx_busy,
        input  tx_data,
        input  tx_start,
        input  tx_sent,
        input  busy
    );

endinterface

// File: rtl/result_tx_serializer.sv
// -----------------------------------------------------------------------------
// result_tx_serializer
//
// Transmit-side responder to the control unit's begin_transmission / tx_sent
// handshake. A result word is latched on an accepted begin_transmission,
// split into bytes and handed to the UART transmitter one byte at a time via
// a tx_start / tx_busy handshake. After the last byte has left the UART a
// single-cycle tx_sent is returned.
//
// Parameters:
//   WORD_WIDTH : width of the result word (multiple of 8)
//   NBYTES     : bytes per word, derived from WORD_WIDTH (do not override)
//   MSB_FIRST  : 1 = most-significant byte first, 0 = least-significant first
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : result_tx_serializer_if.slave
//           begin_transmission (in)  request to send data_in
//           data_in            (in)  word, sampled on the accepted request
//           tx_busy            (in)  UART busy flag
//           tx_data            (out) byte presented to the UART
//           tx_start           (out) one-cycle load strobe for the UART
//           tx_sent            (out) one-cycle "word fully transmitted"
//           busy               (out) word in flight (acceptance .. tx_sent)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module result_tx_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int NBYTES     = WORD_WIDTH / 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    result_tx_serializer_if.slave bus
);

    // Counter is wide enough to index NBYTES bytes, never narrower than 1 bit.
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        NEXT      = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                state_reg,    state_next;
    logic [CNT_W-1:0]      cnt_reg,      cnt_next;
    logic [WORD_WIDTH-1:0] shift_reg,    shift_next;
    logic [7:0]            tx_data_reg,  tx_data_next;
    logic                  tx_start_reg, tx_start_next;
    logic                  tx_sent_reg,  tx_sent_next;
    logic                  busy_reg,     busy_next;

    // Byte at the "send next" end of the shift register, and the register
    // advanced by one byte towards that end.
    logic [7:0]            cur_byte;
    logic [WORD_WIDTH-1:0] shift_adv;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign cur_byte  = shift_reg[WORD_WIDTH-1 -: 8];
            assign shift_adv = shift_reg << 8;
        end else begin : g_lsb_first
            assign cur_byte  = shift_reg[7:0];
            assign shift_adv = shift_reg >> 8;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State / output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            tx_data_reg  <= 8'h00;
            tx_start_reg <= 1'b0;
            tx_sent_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            tx_sent_reg  <= tx_sent_next;
            busy_reg     <= busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        tx_data_next  = tx_data_reg;   // tx_data only moves together with tx_start
        tx_start_next = 1'b0;          // strobes default low: one-cycle pulses
        tx_sent_next  = 1'b0;
        busy_next     = busy_reg;

        case (state_reg)
            IDLE: begin
                if (bus.begin_transmission) begin
                    shift_next = bus.data_in;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                // Never load a byte into a UART that is still shifting.
                if (!bus.tx_busy) begin
                    tx_data_next  = cur_byte;
                    tx_start_next = 1'b1;
                    state_next    = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                // Wait for the UART to acknowledge the load by raising busy.
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = NEXT;
                end
            end

            NEXT: begin
                if (cnt_reg == LAST_BYTE) begin
                    // tx_sent is registered, so it is visible while in DONE,
                    // where busy is still high.
                    tx_sent_next = 1'b1;
                    state_next   = DONE;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    shift_next = shift_adv;
                    state_next = ISSUE;
                end
            end

            DONE: begin
                // A request arriving in this cycle is deliberately dropped.
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.tx_data  = tx_data_reg;
    assign bus.tx_start = tx_start_reg;
    assign bus.tx_sent  = tx_sent_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_result_tx_serializer.sv
`timescale 1ns/1ps
module tb_result_tx_serializer;

    localparam int WW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [1:0]       beg;
    logic [1:0][31:0] din;
    logic [1:0]       ub = '0;          // UART model busy
    logic [1:0]       hold_busy;        // bench override forcing tx_busy high
    logic [1:0][7:0]  tx_data_w;
    logic [1:0]       tx_start_w, tx_sent_w, busy_w, tx_busy_w;

    // Instance 0: MSB first, instance 1: LSB first
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        result_tx_serializer_if #(.WORD_WIDTH(WW)) bus ();
        assign bus.begin_transmission = beg[gi];
        assign bus.data_in            = din[gi];
        assign bus.tx_busy            = ub[gi] | hold_busy[gi];
        assign tx_data_w[gi]          = bus.tx_data;
        assign tx_start_w[gi]         = bus.tx_start;
        assign tx_sent_w[gi]          = bus.tx_sent;
        assign busy_w[gi]             = bus.busy;
        assign tx_busy_w[gi]          = bus.tx_busy;

        result_tx_serializer #(.WORD_WIDTH(WW), .MSB_FIRST(gi == 0)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    // ---------------- UART model: busy for uart_t cycles, one cycle after start
    int uart_t [2];
    int ucnt   [2];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                ub[k]   <= 1'b0;
                ucnt[k] <= 0;
            end else if (ucnt[k] != 0) begin
                ucnt[k] <= ucnt[k] - 1;
                if (ucnt[k] == 1) ub[k] <= 1'b0;
            end else if (tx_start_w[k]) begin
                ub[k]   <= 1'b1;
                ucnt[k] <= uart_t[k];
            end
        end
    end

    // ---------------- Monitor: records bytes / pulses and protocol violations
    logic [7:0] rx_buf [2][512];
    int rx_cnt   [2] = '{0, 0};
    int sent_cnt [2] = '{0, 0};
    int viol     [2] = '{0, 0};
    logic [1:0]      prev_sent = '0;
    logic [1:0][7:0] prev_data = '0;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                prev_sent[k] = 1'b0;
                prev_data[k] = tx_data_w[k];
            end else begin
                if (tx_start_w[k]) begin
                    if (rx_cnt[k] < 512) rx_buf[k][rx_cnt[k]] = tx_data_w[k];
                    rx_cnt[k]++;
                    if (tx_busy_w[k]) viol[k]++;              // start onto busy UART
                end
                if (tx_sent_w[k]) begin
                    sent_cnt[k]++;
                    if (!busy_w[k]) viol[k]++;                // busy must cover tx_sent
                end
                if (prev_sent[k] && busy_w[k]) viol[k]++;     // busy low after tx_sent
                if (tx_busy_w[k] && tx_data_w[k] != prev_data[k]) viol[k]++;
                prev_sent[k] = tx_sent_w[k];
                prev_data[k] = tx_data_w[k];
            end
        end
    end

    // ---------------- Checking helpers
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: i-th byte on the wire for word w
    function automatic logic [7:0] model_byte(input logic [31:0] w, input bit lsb, input int i);
        logic [31:0] s;
        s = lsb ? (w >> (8 * i)) : (w >> (8 * (3 - i)));
        return s[7:0];
    endfunction

    task automatic send(input int sel, input logic [31:0] w);
        din[sel] = w;
        beg[sel] = 1'b1;
        tick();
        beg[sel] = 1'b0;
        chk("busy_after_accept", busy_w[sel], 1);
    endtask

    task automatic wait_sent(input int sel, input int limit);
        int n = 0;
        while (!tx_sent_w[sel] && n < limit) begin
            tick();
            n++;
        end
        if (!tx_sent_w[sel]) chk("tx_sent_timeout", tx_sent_w[sel], 1);
    endtask

    task automatic wait_bytes(input int sel, input int target, input int limit);
        int n = 0;
        while (rx_cnt[sel] < target && n < limit) begin
            tick();
            n++;
        end
        if (rx_cnt[sel] < target) chk("byte_timeout", rx_cnt[sel], target);
    endtask

    task automatic check_word(input int sel, input int base, input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            chk("byte", rx_buf[sel][base + i], model_byte(w, sel == 1, i));
        $display("word inst=%0d data=%08h bytes %02h %02h %02h %02h", sel, w,
                 rx_buf[sel][base], rx_buf[sel][base + 1], rx_buf[sel][base + 2], rx_buf[sel][base + 3]);
    endtask

    typedef struct {
        int          sel;
        logic [31:0] word;
        int          t;
        logic [31:0] exp_stream;   // bytes in wire order, first byte in [31:24]
    } vec_t;

    vec_t tbl [6];

    initial begin
        int base, s0, r;
        logic [31:0] w, stream;

        tbl[0] = '{0, 32'h12345678, 10, 32'h12345678};
        tbl[1] = '{1, 32'h000000F1, 10, 32'hF1000000};
        tbl[2] = '{1, 32'h12345678,  3, 32'h78563412};
        tbl[3] = '{0, 32'hDEADBEEF,  1, 32'hDEADBEEF};
        tbl[4] = '{1, 32'hA1B2C3D4,  5, 32'hD4C3B2A1};
        tbl[5] = '{0, 32'h00FF00FF,  2, 32'h00FF00FF};

        reset = 1'b1;
        beg = '0;
        din = '0;
        hold_busy = '0;
        uart_t[0] = 10;
        uart_t[1] = 10;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx_data", tx_data_w[k], 8'h00);
            chk("rst_tx_start", tx_start_w[k], 0);
            chk("rst_tx_sent", tx_sent_w[k], 0);
            chk("rst_busy", busy_w[k], 0);
        end
        reset = 1'b0;
        tick();

        // ---------------- Table-driven words
        for (int v = 0; v < 6; v++) begin
            uart_t[tbl[v].sel] = tbl[v].t;
            base = rx_cnt[tbl[v].sel];
            s0   = sent_cnt[tbl[v].sel];
            send(tbl[v].sel, tbl[v].word);
            wait_sent(tbl[v].sel, 1000);
            tick();
            chk("busy_drop_after_sent", busy_w[tbl[v].sel], 0);
            tick();
            chk("tbl_byte_count", rx_cnt[tbl[v].sel] - base, 4);
            stream = tbl[v].exp_stream;
            for (int i = 0; i < 4; i++)
                chk("tbl_byte", rx_buf[tbl[v].sel][base + i], stream[31 - 8 * i -: 8]);
            chk("tbl_sent_count", sent_cnt[tbl[v].sel] - s0, 1);
            $display("vector %0d inst=%0d data=%08h done", v, tbl[v].sel, tbl[v].word);
        end

        // ---------------- UART busy for 20 cycles when request arrives
        uart_t[0] = 4;
        hold_busy[0] = 1'b1;
        base = rx_cnt[0];
        send(0, 32'hCAFE0001);
        repeat (19) begin
            tick();
            chk("no_start_while_busy", tx_start_w[0], 0);
        end
        hold_busy[0] = 1'b0;
        tick();
        chk("start_after_busy_fall", tx_start_w[0], 1);
        chk("first_byte_after_fall", tx_data_w[0], 8'hCA);
        wait_sent(0, 1000);
        tick();
        check_word(0, base, 32'hCAFE0001);

        // ---------------- Request during byte 2 is ignored
        uart_t[0] = 10;
        base = rx_cnt[0];
        s0 = sent_cnt[0];
        send(0, 32'h11223344);
        wait_bytes(0, base + 2, 500);
        din[0] = 32'hDEADBEEF;
        beg[0] = 1'b1;
        tick();
        beg[0] = 1'b0;
        wait_sent(0, 1000);
        repeat (60) tick();
        chk("ignored_req_bytes", rx_cnt[0] - base, 4);
        check_word(0, base, 32'h11223344);
        chk("ignored_req_sent", sent_cnt[0] - s0, 1);

        // ---------------- Reset during WAIT_DONE of byte 3
        base = rx_cnt[0];
        send(0, 32'hCAFEF00D);
        wait_bytes(0, base + 3, 500);
        wait_bytes(0, base + 3, 0);
        r = 0;
        while (!tx_busy_w[0] && r < 20) begin
            tick();
            r++;
        end
        repeat (2) tick();
        s0 = sent_cnt[0];
        reset = 1'b1;
        tick();
        chk("midrst_tx_data", tx_data_w[0], 8'h00);
        chk("midrst_tx_start", tx_start_w[0], 0);
        chk("midrst_tx_sent", tx_sent_w[0], 0);
        chk("midrst_busy", busy_w[0], 0);
        reset = 1'b0;
        repeat (30) tick();
        chk("abandoned_no_sent", sent_cnt[0] - s0, 0);
        chk("abandoned_bytes", rx_cnt[0] - base, 3);
        base = rx_cnt[0];
        send(0, 32'h55AA1234);
        wait_sent(0, 1000);
        tick();
        check_word(0, base, 32'h55AA1234);

        // ---------------- Eight back-to-back words 10..24
        base = rx_cnt[0];
        s0 = sent_cnt[0];
        for (int i = 0; i < 8; i++) begin
            send(0, 32'(10 + 2 * i));
            wait_sent(0, 1000);
            tick();
        end
        tick();
        chk("b2b_byte_count", rx_cnt[0] - base, 32);
        chk("b2b_sent_count", sent_cnt[0] - s0, 8);
        for (int i = 0; i < 8; i++) check_word(0, base + 4 * i, 32'(10 + 2 * i));

        // ---------------- Randomized words with spurious requests
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = int'($urandom_range(0, 1));
            w = $urandom;
            uart_t[sel] = int'($urandom_range(1, 12));
            base = rx_cnt[sel];
            s0 = sent_cnt[sel];
            send(sel, w);
            if ($urandom_range(0, 1) == 1) begin
                wait_bytes(sel, base + int'($urandom_range(1, 3)), 500);
                din[sel] = $urandom;
                beg[sel] = 1'b1;
                tick();
                beg[sel] = 1'b0;
            end
            wait_sent(sel, 1000);
            tick();
            repeat ($urandom_range(0, 2)) tick();
            chk("rnd_byte_count", rx_cnt[sel] - base, 4);
            check_word(sel, base, w);
            chk("rnd_sent_count", sent_cnt[sel] - s0, 1);
        end

        repeat (20) tick();
        chk("protocol_viol_msb", viol[0], 0);
        chk("protocol_viol_lsb", viol[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_tx_serializer.md
Name: result_tx_serializer

Overview:
- Transmit-side responder to the processing control unit's `begin_transmission` / `tx_sent` handshake.
- On each `begin_transmission` pulse it latches one 32-bit result word (`par_result` element or `man_result`, selected upstream) and splits it into bytes.
- Bytes are pushed one at a time into the UART transmitter through a start/busy handshake.
- When the last byte has left the UART it returns a single-cycle `tx_sent`, so the control unit can shift memory and request the next word.

Parameters:
- WORD_WIDTH, 32, width of the result word; must be a multiple of 8.
- NBYTES, WORD_WIDTH/8, bytes sent per word (derived; not overridden).
- MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant byte first.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- begin_transmission  input  1  single-cycle request from the control unit to send `data_in`
- data_in  input  WORD_WIDTH  result word; sampled only on the accepted `begin_transmission` cycle
- tx_busy  input  1  UART transmitter busy flag; high while a byte is shifting out
- tx_data  output  8  byte presented to the UART
- tx_start  output  1  single-cycle pulse; UART loads `tx_data` on this cycle
- tx_sent  output  1  single-cycle pulse; whole word transmitted
- busy  output  1  high from word acceptance until the cycle `tx_sent` is asserted, inclusive

Behaviour:
- Reset values: `tx_data` = 0x00, `tx_start` = 0, `tx_sent` = 0, `busy` = 0, state = IDLE, byte counter = 0, shift register = 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, DONE.
- IDLE:
  - If `begin_transmission` = 1 at a rising edge: latch `data_in` into the shift register, clear the byte counter, set `busy` = 1, go to ISSUE.
  - Otherwise stay.
- ISSUE:
  - If `tx_busy` = 0: drive `tx_data` with the current byte and pulse `tx_start` for exactly one cycle, then go to WAIT_ACK.
  - If `tx_busy` = 1: hold `tx_start` = 0 and stay, so no byte is ever issued onto a busy UART.
  - Current byte = bits [WORD_WIDTH-1 -: 8] when MSB_FIRST = 1, else bits [7:0].
- WAIT_ACK: wait for `tx_busy` = 1, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_busy` = 0, then go to NEXT.
- NEXT:
  - If counter = NBYTES-1: go to DONE.
  - Else: increment the counter, shift the register by 8 (left when MSB_FIRST = 1, right otherwise), go to ISSUE.
- DONE: `tx_sent` = 1 for exactly one cycle, `busy` = 0 on the following cycle, return to IDLE.
- `tx_data` holds its value from the `tx_start` cycle until the next `tx_start`; it is never changed while `tx_busy` is high.
- `begin_transmission` while `busy` = 1 (any state other than IDLE) is ignored: no latch, no queueing, no error flag.
- `begin_transmission` on the same cycle `tx_sent` pulses is ignored. The control unit must not re-request before seeing `tx_sent`.
- Minimum latency, assuming a UART that raises busy 1 cycle after start and holds it for T cycles:
  - per byte: ISSUE(1) + WAIT_ACK(1) + WAIT_DONE(T) + NEXT(1);
  - `tx_sent` follows one cycle after the final NEXT.
- Reset asserted mid-word (any state): next edge forces IDLE and all reset values, including `tx_start` = 0; a partially sent word is abandoned.
- `tx_sent` is not generated for an abandoned word.
- No arithmetic beyond the counter, which is ceil(log2(NBYTES)) bits wide, minimum 1, and never wraps past NBYTES-1.

Test Plan:
- MSB_FIRST=1, `data_in` = 0x12345678, one `begin_transmission` pulse, UART model with 10-cycle busy -> `tx_start` pulses 4 times carrying 0x12, 0x34, 0x56, 0x78 in order; exactly one `tx_sent` after the 4th `tx_busy` fall; `busy` drops one cycle later.
- MSB_FIRST=0, `data_in` = 0x000000F1 -> byte order 0xF1, 0x00, 0x00, 0x00; single `tx_sent`.
- `tx_busy` held high for 20 cycles when the request arrives -> `tx_start` stays 0 throughout; first byte is issued the cycle after `tx_busy` falls.
- Second `begin_transmission` with 0xDEADBEEF during byte 2 of 0x11223344 -> only bytes 0x11, 0x22, 0x33, 0x44 are sent; no further `tx_start` afterwards; one `tx_sent`.
- `reset` asserted for 1 cycle while in WAIT_DONE of byte 3 -> next cycle all outputs are at reset values; no `tx_sent`; a new request then sends its full 4 bytes correctly.
- Eight back-to-back words 10, 12, 14, …, 24 (SUM results for A=i, B=10+i), each new request issued on `tx_sent` -> 32 bytes received in order, 8 `tx_sent` pulses, no dropped or duplicated byte.
